// File: rtl/calc_if.sv
// calc_if: keypad-to-engine bundle carrying key pulses in and display/status out.
//   master: drives key_digit, operator keys, op_neg, ce, ac; reads the display outputs.
//   slave : the calc_engine side of the same signals.
interface calc_if #(parameter int RW = 28) ();
  logic [9:0] key_digit;
  logic op_add, op_sub, op_mul, op_div, op_sqr, op_eq, op_neg, ce, ac;
  logic [RW-2:0] out_mag;
  logic sign, overflow, div_zero, busy;
  modport master (
    output key_digit, op_add, op_sub, op_mul, op_div, op_sqr, op_eq, op_neg, ce, ac,
    input out_mag, sign, overflow, div_zero, busy
  );
  modport slave (
    input key_digit, op_add, op_sub, op_mul, op_div, op_sqr, op_eq, op_neg, ce, ac,
    output out_mag, sign, overflow, div_zero, busy
  );
endinterface

// File: rtl/calc_engine.sv
// calc_engine: keypad-driven signed decimal calculator with serial restoring divider.
//   sys_clk : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   io      : calc_if slave (keys in; out_mag/sign/overflow/div_zero/busy out)
module calc_engine #(
  parameter int DIGITS  = 4,
  parameter int AW      = 15,
  parameter int RW      = 28,
  parameter int MAX_MAG = 99980001
) (
  input logic sys_clk,
  input logic rst_n,
  calc_if.slave io
);
  localparam int WW = 2 * RW;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int YW = $clog2(RW);
  localparam int OW = RW - 1;
  localparam logic [CW-1:0] DMAX = CW'(DIGITS);
  localparam logic [YW-1:0] CYC_END = YW'(RW - 1);
  localparam logic [WW-1:0] MAXW = WW'(MAX_MAG);

  typedef enum logic [1:0] {ENTRY, SHOW, BUSY, ERR} state_t;
  typedef enum logic [2:0] {P_ADD, P_SUB, P_MUL, P_DIV, P_SQR, P_LOAD} pend_t;

  state_t state;
  pend_t pend, op_pend;
  logic [AW-1:0] a, rem, dv, rem_nx;
  logic a_neg, q_neg, overflow, div_zero;
  logic [CW-1:0] count;
  logic signed [RW-1:0] b, b_div;
  logic [RW-1:0] b_mag, dq, dq_nx;
  logic [YW-1:0] cyc;
  logic [3:0] d;
  logic dig_hit, op_hit, take, res_ovf;
  logic [AW:0] r2;
  logic signed [WW-1:0] bw, aw, sw, res;
  logic [WW-1:0] res_mag;

  // highest set digit bit wins
  always_comb begin
    d = '0;
    for (int i = 0; i < 10; i++) if (io.key_digit[i]) d = 4'(i);
  end

  assign dig_hit = |io.key_digit;
  assign op_hit = io.op_add | io.op_sub | io.op_mul | io.op_div | io.op_sqr | io.op_eq;
  assign op_pend = io.op_add ? P_ADD : io.op_sub ? P_SUB : io.op_mul ? P_MUL :
                   io.op_div ? P_DIV : io.op_sqr ? P_SQR : P_LOAD;

  // arithmetic at double width so the range check sees the true result
  assign bw = {{RW{b[RW-1]}}, b};
  assign aw = $signed(WW'(a));
  assign sw = a_neg ? -aw : aw;
  assign res = pend == P_SUB ? bw - sw :
               pend == P_MUL ? bw * sw :
               pend == P_SQR ? sw * sw :
               pend == P_LOAD ? sw : bw + sw;
  assign res_mag = res[WW-1] ? -res : res;
  assign res_ovf = res_mag > MAXW;
  assign b_mag = b[RW-1] ? -b : b;

  // one restoring step: shift next dividend bit into the remainder, subtract if it fits
  assign r2 = {rem, dq[RW-1]};
  assign take = r2 >= {1'b0, dv};
  assign rem_nx = AW'(take ? r2 - {1'b0, dv} : r2);
  assign dq_nx = {dq[RW-2:0], take};
  // negating a zero quotient stays zero, so it is never shown negative
  assign b_div = q_neg ? -$signed(dq_nx) : $signed(dq_nx);

  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state <= ENTRY;
      pend <= P_ADD;
      a <= '0;
      a_neg <= 1'b0;
      count <= '0;
      b <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
      dq <= '0;
      rem <= '0;
      dv <= '0;
      q_neg <= 1'b0;
      cyc <= '0;
    end else if (io.ac || (state == ERR && io.ce)) begin
      state <= ENTRY;
      pend <= P_ADD;
      a <= '0;
      a_neg <= 1'b0;
      count <= '0;
      b <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else
      case (state)
        ENTRY:
          if (io.ce) begin
            a <= '0;
            a_neg <= 1'b0;
            count <= '0;
          end else if (dig_hit) begin
            if (count < DMAX) begin
              a <= a * AW'(10) + AW'(d);
              count <= count + 1'b1;
            end
          end else if (io.op_neg) a_neg <= ~a_neg;
          else if (op_hit) begin
            if (pend == P_DIV) begin
              if (a == '0) begin
                state <= ERR;
                div_zero <= 1'b1;
              end else begin
                state <= BUSY;
                pend <= op_pend;
                dq <= b_mag;
                rem <= '0;
                dv <= a;
                q_neg <= b[RW-1] ^ a_neg;
                cyc <= '0;
              end
            end else if (res_ovf) begin
              state <= ERR;
              overflow <= 1'b1;
            end else begin
              state <= SHOW;
              pend <= op_pend;
              b <= res[RW-1:0];
            end
          end
        SHOW:
          if (io.ce) begin
            state <= ENTRY;
            a <= '0;
            a_neg <= 1'b0;
            count <= '0;
          end else if (dig_hit) begin
            state <= ENTRY;
            a <= AW'(d);
            a_neg <= 1'b0;
            count <= CW'(1);
          end else if (io.op_neg) b <= -b;
          else if (op_hit) pend <= op_pend;
        BUSY: begin
          dq <= dq_nx;
          rem <= rem_nx;
          cyc <= cyc + 1'b1;
          if (cyc == CYC_END) begin
            state <= SHOW;
            b <= b_div;
          end
        end
        default: ;
      endcase

  assign io.out_mag = state == ERR ? '0 : state == ENTRY ? OW'(a) : OW'(b_mag);
  assign io.sign = state == ENTRY ? a_neg : state != ERR && b[RW-1];
  assign io.overflow = overflow;
  assign io.div_zero = div_zero;
  assign io.busy = state == BUSY;
endmodule
